// File: rtl/muldiv_iter_if.sv
// Start/done handshake bundle for the iterative RV32M multiply/divide unit.
// The master drives the request; the slave (muldiv_iter) returns busy/done/result.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             iStart;
  logic [2:0]       iFunct3;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oBusy;
  logic             oDone;
  logic [WIDTH-1:0] oResult;

  modport master (
    output iStart, iFunct3, iA, iB,
    input  oBusy, oDone, oResult
  );

  modport slave (
    input  iStart, iFunct3, iA, iB,
    output oBusy, oDone, oResult
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on magnitudes,
// STEPS bits per cycle, sign fix-up at the end. Macro MULDIV_REUSE_EN adds a DIV<->REM result tag.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  muldiv_iter_if.slave  mdu
);

  localparam int N  = WIDTH / STEPS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_SPEC,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [2:0]       r_funct3;
  logic             r_neg_a;
  logic             r_neg_b;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mcand;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  // Request decode, evaluated on the raw interface operands
  logic             w_is_div;
  logic             w_a_signed;
  logic             w_b_signed;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_div_zero;
  logic             w_div_ovf;
  logic             w_reuse_hit;
  logic [WIDTH-1:0] w_reuse_val;
  logic             w_spec;
  logic [WIDTH-1:0] w_spec_val;

  assign w_is_div   = mdu.iFunct3[2];
  assign w_a_signed = (mdu.iFunct3 == 3'b001) || (mdu.iFunct3 == 3'b010) ||
                      (mdu.iFunct3 == 3'b100) || (mdu.iFunct3 == 3'b110);
  assign w_b_signed = (mdu.iFunct3 == 3'b001) ||
                      (mdu.iFunct3 == 3'b100) || (mdu.iFunct3 == 3'b110);
  assign w_neg_a    = w_a_signed && mdu.iA[WIDTH-1];
  assign w_neg_b    = w_b_signed && mdu.iB[WIDTH-1];
  // The most negative value negates to itself, which is already its correct unsigned magnitude.
  assign w_abs_a    = w_neg_a ? -mdu.iA : mdu.iA;
  assign w_abs_b    = w_neg_b ? -mdu.iB : mdu.iB;

  assign w_div_zero = w_is_div && (mdu.iB == '0);
  assign w_div_ovf  = w_is_div && !mdu.iFunct3[0] &&
                      (mdu.iA == {1'b1, {(WIDTH-1){1'b0}}}) && (mdu.iB == '1);
  assign w_spec     = w_div_zero || w_div_ovf || w_reuse_hit;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_spec_val = w_reuse_val;
    if (w_div_zero)
      w_spec_val = mdu.iFunct3[1] ? mdu.iA : '1;
    else if (w_div_ovf)
      w_spec_val = mdu.iFunct3[1] ? '0 : mdu.iA;
  end

  // STEPS iterations of the shared datapath, unrolled combinationally
  logic [WIDTH-1:0] w_hi_nx;
  logic [WIDTH-1:0] w_lo_nx;
  logic [WIDTH:0]   w_t;

  always_comb begin
    // NOTE: blocking assignments here chain each unrolled step into the next one.
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    w_t     = '0;
    for (int s = 0; s < STEPS; s++) begin
      if (r_funct3[2]) begin
        w_t     = {w_hi_nx, w_lo_nx[WIDTH-1]};
        w_lo_nx = {w_lo_nx[WIDTH-2:0], 1'b0};
        if (w_t >= {1'b0, r_mcand}) begin
          w_t        = w_t - {1'b0, r_mcand};
          w_lo_nx[0] = 1'b1;
        end
        w_hi_nx = w_t[WIDTH-1:0];
      end else begin
        w_t     = {1'b0, w_hi_nx} + (w_lo_nx[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_lo_nx = {w_t[0], w_lo_nx[WIDTH-1:1]};
        w_hi_nx = w_t[WIDTH:1];
      end
    end
  end

  // Sign correction and result selection
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_val;

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
  assign w_quo    = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
  assign w_rem    = r_neg_a ? -r_hi : r_hi;

  always_comb begin
    w_fix_val = w_prod_s[WIDTH-1:0];
    case (r_funct3)
      3'b001, 3'b010, 3'b011: w_fix_val = w_prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_fix_val = w_quo;
      3'b110, 3'b111:         w_fix_val = w_rem;
      default:                w_fix_val = w_prod_s[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_state  <= S_IDLE;
      r_funct3 <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mcand  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (mdu.iStart) begin
            r_funct3 <= mdu.iFunct3;
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
            r_cnt    <= CW'(N);
            r_hi     <= '0;
            r_busy   <= 1'b1;
            if (w_spec) begin
              r_lo    <= w_spec_val;
              r_mcand <= '0;
              r_state <= S_SPEC;
            end else begin
              r_lo    <= w_is_div ? w_abs_a : w_abs_b;
              r_mcand <= w_is_div ? w_abs_b : w_abs_a;
              r_state <= S_CALC;
            end
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1))
            r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix_val;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_DONE;
        end
        S_SPEC: begin
          r_result <= r_lo;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_DONE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MULDIV_REUSE_EN
  // Tag of the last iterated divide: operands, signedness and both signed results
  logic             w_accept;
  logic [WIDTH-1:0] r_cur_a;
  logic [WIDTH-1:0] r_cur_b;
  logic             r_tag_valid;
  logic [WIDTH-1:0] r_tag_a;
  logic [WIDTH-1:0] r_tag_b;
  logic             r_tag_uns;
  logic             r_tag_rem;
  logic [WIDTH-1:0] r_tag_q;
  logic [WIDTH-1:0] r_tag_r;

  assign w_accept    = mdu.iStart && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_reuse_hit = r_tag_valid && w_is_div &&
                       (mdu.iA == r_tag_a) && (mdu.iB == r_tag_b) &&
                       (mdu.iFunct3[0] == r_tag_uns) && (mdu.iFunct3[1] != r_tag_rem);
  assign w_reuse_val = mdu.iFunct3[1] ? r_tag_r : r_tag_q;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_cur_a     <= '0;
      r_cur_b     <= '0;
      r_tag_valid <= 1'b0;
      r_tag_a     <= '0;
      r_tag_b     <= '0;
      r_tag_uns   <= 1'b0;
      r_tag_rem   <= 1'b0;
      r_tag_q     <= '0;
      r_tag_r     <= '0;
    end else begin
      if (w_accept) begin
        r_cur_a <= mdu.iA;
        r_cur_b <= mdu.iB;
        if (!w_is_div)
          r_tag_valid <= 1'b0;
      end
      if ((r_state == S_FIX) && r_funct3[2]) begin
        r_tag_valid <= 1'b1;
        r_tag_a     <= r_cur_a;
        r_tag_b     <= r_cur_b;
        r_tag_uns   <= r_funct3[0];
        r_tag_rem   <= r_funct3[1];
        r_tag_q     <= w_quo;
        r_tag_r     <= w_rem;
      end
    end
  end
`else
  assign w_reuse_hit = 1'b0;
  assign w_reuse_val = '0;
`endif

  assign mdu.oBusy   = r_busy;
  assign mdu.oDone   = r_done;
  assign mdu.oResult = r_result;

endmodule
